// File: rtl/nr_div_if.sv
// nr_div_if: handshake and data bundle for the sequential signed divider.
//   start  requester -> divider  request, taken only when the divider is idle
//   a, b   requester -> divider  signed dividend / divisor, sampled on accept
//   busy   divider -> requester  operation in flight
//   done   divider -> requester  one-cycle pulse, q/r/dz/ovf valid
//   q, r   divider -> requester  truncated quotient and remainder
//   dz     divider -> requester  last completed operation divided by zero
//   ovf    divider -> requester  last completed operation was min / -1
interface nr_div_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, q, r, dz, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, dz, ovf
  );
endinterface

// File: rtl/nr_div.sv
// nr_div: sequential signed divider, one non-restoring quotient bit per clock.
// Produces q = trunc(a/b) and r = a - q*b with the remainder taking the sign
// of the dividend. Latency is WIDTH+1 edges from accept to done.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation in flight
//   bus    nr_div_if slave: start/a/b in; busy/done/q/r/dz/ovf out
module nr_div #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  nr_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int               CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mag_a_reg;
  logic [WIDTH-1:0] mag_b_reg;
  // Holds |a| at accept; dividend bits shift out of the top while quotient
  // bits shift in at the bottom, so after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] quo_reg;
  // Signed partial remainder, one bit wider than the operands.
  logic [WIDTH:0]   rem_reg;
  logic             sign_a_reg;
  logic             sign_q_reg;
  logic             dz_op_reg;
  logic             ovf_op_reg;

  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dz_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] rem_corr;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    abs_a     = '0;
    abs_b     = '0;
    rem_shift = '0;
    rem_step  = '0;
    rem_corr  = '0;
    r_mag     = '0;
    q_fix     = '0;
    r_fix     = '0;

    // Magnitudes as unsigned WIDTH-bit values: |min| wraps to the same bit
    // pattern, which read unsigned is exactly 2^(WIDTH-1).
    abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Non-restoring step: subtract while the remainder is non-negative,
    // add back while it is negative; the new sign decides the quotient bit.
    rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    rem_step  = rem_reg[WIDTH] ? (rem_shift + {1'b0, mag_b_reg})
                               : (rem_shift - {1'b0, mag_b_reg});

    // Final correction only touches the remainder; the quotient bits are
    // already the restoring-division digits. The true corrected value lies
    // in [0, |b|), so WIDTH-bit modular arithmetic is exact.
    rem_corr = rem_reg[WIDTH-1:0] + (rem_reg[WIDTH] ? mag_b_reg : '0);

    // Divide by zero reports r = a, rebuilt from |a| and the sign below.
    r_mag = dz_op_reg ? mag_a_reg : rem_corr;

    if (dz_op_reg) begin
      q_fix = '1;
    end else if (ovf_op_reg) begin
      q_fix = MIN_VAL;
    end else begin
      q_fix = sign_q_reg ? -quo_reg : quo_reg;
    end

    if (ovf_op_reg && !dz_op_reg) begin
      r_fix = '0;
    end else begin
      r_fix = sign_a_reg ? -r_mag : r_mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_q_reg <= 1'b0;
      dz_op_reg  <= 1'b0;
      ovf_op_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      q_reg      <= '0;
      r_reg      <= '0;
      dz_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mag_a_reg  <= abs_a;
            mag_b_reg  <= abs_b;
            quo_reg    <= abs_a;
            rem_reg    <= '0;
            sign_a_reg <= bus.a[WIDTH-1];
            sign_q_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            dz_op_reg  <= (bus.b == '0);
            ovf_op_reg <= (bus.a == MIN_VAL) && (bus.b == '1);
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= {quo_reg[WIDTH-2:0], ~rem_step[WIDTH]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          q_reg     <= q_fix;
          r_reg     <= r_fix;
          dz_reg    <= dz_op_reg;
          ovf_reg   <= ovf_op_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.dz   = dz_reg;
  assign bus.ovf  = ovf_reg;

endmodule
